// File: rtl/ltf_frame_gate.sv
`default_nettype none
// ============================================================================
// Module   : ltf_frame_gate
// Function : Aligns to a programmable offset after each LTF peak, then forwards
//            one framed AXIS burst with tsof/tlast, followed by a holdoff.
// Revision : 1.0 - initial release
// ============================================================================
module ltf_frame_gate #(
  parameter int DATA_WIDTH = 16,
  parameter int NRX_WIDTH  = 16,
  parameter int PMAG_WIDTH = 26,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    peak_stb,
  input  logic [NRX_WIDTH-1:0]    nrx_after_peak,
  input  logic [PMAG_WIDTH-1:0]   pow,
  input  logic [CNT_WIDTH-1:0]    align_offset,
  input  logic [CNT_WIDTH-1:0]    frame_len,
  input  logic [CNT_WIDTH-1:0]    holdoff,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic                    out_tsof,
  output logic [PMAG_WIDTH-1:0]   frame_pow,
  output logic [CNT_WIDTH-1:0]    frame_idx,
  output logic [CNT_WIDTH-1:0]    missed_peaks,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALIGN   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_next;
  logic [CNT_WIDTH-1:0]    r_skip, r_len, r_hold;
  logic                    r_first;
  logic [2*DATA_WIDTH-1:0] r_out_tdata;
  logic                    r_out_tvalid, r_out_tlast, r_out_tsof;
  logic [PMAG_WIDTH-1:0]   r_frame_pow;
  logic [CNT_WIDTH-1:0]    r_frame_idx, r_missed;

  logic                    w_rst, w_in_ready, w_in_beat, w_cap_beat, w_out_xfer, w_accept;
  logic [CNT_WIDTH-1:0]    w_nrx_cnt, w_skip_init, w_len_init;
  logic [CNT_WIDTH:0]      w_diff;

  generate
    if (NRX_WIDTH >= CNT_WIDTH) begin : g_nrx_trunc
      assign w_nrx_cnt = nrx_after_peak[CNT_WIDTH-1:0];
    end else begin : g_nrx_zext
      assign w_nrx_cnt = {{(CNT_WIDTH-NRX_WIDTH){1'b0}}, nrx_after_peak};
    end
  endgenerate

  assign w_rst       = reset | clear;
  // A negative difference means the peak is already behind us: capture at once.
  assign w_diff      = {1'b0, align_offset} - {1'b0, w_nrx_cnt};
  assign w_skip_init = w_diff[CNT_WIDTH] ? '0 : w_diff[CNT_WIDTH-1:0];
  assign w_len_init  = (frame_len == '0) ? c_cnt_one : frame_len;

  assign w_in_ready  = (r_state == S_CAPTURE) ? (~r_out_tvalid | out_tready) : 1'b1;
  assign w_in_beat   = in_tvalid & w_in_ready;
  assign w_cap_beat  = (r_state == S_CAPTURE) & w_in_beat;
  assign w_out_xfer  = r_out_tvalid & out_tready;
  assign w_accept    = (r_state == S_IDLE) & peak_stb;

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (peak_stb) w_state_next = (w_skip_init != '0) ? S_ALIGN : S_CAPTURE;
      S_ALIGN:   if (w_in_beat && r_skip == c_cnt_one) w_state_next = S_CAPTURE;
      S_CAPTURE: if (w_in_beat && r_len == c_cnt_one) w_state_next = S_HOLDOFF;
      S_HOLDOFF: begin
        if (r_hold == '0)                             w_state_next = S_IDLE;
        else if (w_in_beat && r_hold == c_cnt_one)    w_state_next = S_IDLE;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_skip  <= '0;
      r_len   <= '0;
      r_hold  <= '0;
      r_first <= 1'b0;
    end else begin
      if (w_accept) begin
        r_skip  <= w_skip_init;
        r_len   <= w_len_init;
        r_hold  <= holdoff;
        r_first <= 1'b1;
      end
      if (r_state == S_ALIGN && w_in_beat) r_skip <= r_skip - c_cnt_one;
      if (w_cap_beat) begin
        r_len   <= r_len - c_cnt_one;
        r_first <= 1'b0;
      end
      if (r_state == S_HOLDOFF && w_in_beat && r_hold != '0) r_hold <= r_hold - c_cnt_one;
    end
  end

  // Output register drains on its own, so HOLDOFF may start with a beat pending.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_out_tdata  <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
      r_out_tsof   <= 1'b0;
    end else if (w_cap_beat) begin
      r_out_tdata  <= in_tdata;
      r_out_tvalid <= 1'b1;
      r_out_tsof   <= r_first;
      r_out_tlast  <= (r_len == c_cnt_one);
    end else if (w_out_xfer) begin
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
      r_out_tsof   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_frame_pow <= '0;
      r_frame_idx <= '0;
      r_missed    <= '0;
    end else begin
      if (w_accept) begin
        r_frame_pow <= pow;
        r_frame_idx <= r_frame_idx + c_cnt_one;
      end
      if (peak_stb && r_state != S_IDLE && r_missed != '1) r_missed <= r_missed + c_cnt_one;
    end
  end

  assign in_tready    = w_in_ready;
  assign out_tdata    = r_out_tdata;
  assign out_tvalid   = r_out_tvalid;
  assign out_tlast    = r_out_tlast;
  assign out_tsof     = r_out_tsof;
  assign frame_pow    = r_frame_pow;
  assign frame_idx    = r_frame_idx;
  assign missed_peaks = r_missed;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ltf_frame_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltf_frame_gate
// Function : Directed vector table plus randomized run against a beat-ordinal
//            reference model of ltf_frame_gate.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltf_frame_gate;
  localparam int DW = 16;
  localparam int NW = 16;
  localparam int PW = 26;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [2*DW-1:0] in_tdata;
  logic            in_tvalid, in_tready, peak_stb;
  logic [NW-1:0]   nrx_after_peak;
  logic [PW-1:0]   pow;
  logic [CW-1:0]   align_offset, frame_len, holdoff;
  logic [2*DW-1:0] out_tdata;
  logic            out_tvalid, out_tready, out_tlast, out_tsof, busy;
  logic [PW-1:0]   frame_pow;
  logic [CW-1:0]   frame_idx, missed_peaks;

  ltf_frame_gate #(.DATA_WIDTH(DW), .NRX_WIDTH(NW), .PMAG_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .peak_stb(peak_stb), .nrx_after_peak(nrx_after_peak), .pow(pow),
    .align_offset(align_offset), .frame_len(frame_len), .holdoff(holdoff),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_tsof(out_tsof), .frame_pow(frame_pow),
    .frame_idx(frame_idx), .missed_peaks(missed_peaks), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; bit sof; bit last; } beat_t;
  typedef struct {
    int align; int nrx; int flen; int hold; int peak_at; int xa; int xb;
    bit toggle; int abort; bit do_reset;
    int e_n; int e_first; int e_lastd; int e_sof; int e_last; int e_missed; int e_idx; int e_tail;
  } vec_t;

  int checks, failures, cyc;

  // Reference model: a frame is the run of input beats with ordinal skip+1..skip+len
  // counted after the accepting cycle; the block idles after skip+len+hold beats.
  beat_t         m_q[$];
  bit            m_busy, m_end;
  int            m_k, m_skip, m_len, m_hold;
  logic [CW-1:0] m_idx, m_missed;
  logic [PW-1:0] m_pow;

  bit            g_in_beat, g_pre_busy;
  int            st_n, st_sof, st_last, t_lastcap, t_fall;
  logic [31:0]   st_first, st_lastd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_end = 0; m_k = 0; m_skip = 0; m_len = 0; m_hold = 0;
    m_idx = '0; m_missed = '0; m_pow = '0;
  endtask

  task automatic model_step();
    int d;
    if (!m_busy) begin
      if (peak_stb) begin
        d      = int'(align_offset) - int'(nrx_after_peak);
        m_skip = (d > 0) ? d : 0;
        m_len  = (frame_len == '0) ? 1 : int'(frame_len);
        m_hold = int'(holdoff);
        m_k    = 0; m_idx++; m_pow = pow; m_busy = 1; m_end = 0;
      end
    end else begin
      if (peak_stb && m_missed != '1) m_missed++;
      if (m_end) begin
        m_busy = 0; m_end = 0;
      end else if (g_in_beat) begin
        if (m_k >= m_skip && m_k < m_skip + m_len) begin
          m_q.push_back('{in_tdata, m_k == m_skip, m_k == m_skip + m_len - 1});
          if (m_k == m_skip + m_len - 1) t_lastcap = cyc;
        end
        m_k++;
        if (m_hold == 0 && m_k == m_skip + m_len) m_end = 1;
        else if (m_hold > 0 && m_k == m_skip + m_len + m_hold) m_busy = 0;
      end
    end
  endtask

  // Inputs are already driven; compare, predict this edge's handshakes, advance one clock.
  task automatic tick();
    bit cap, exp_ready, out_xfer, rst_now;
    #1;
    g_pre_busy = m_busy;
    cap       = m_busy && !m_end && m_k >= m_skip && m_k < m_skip + m_len;
    exp_ready = !cap || m_q.size() == 0 || out_tready;
    check("busy", busy, m_busy);
    check("out_tvalid", out_tvalid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("out_tdata", out_tdata, m_q[0].d);
      check("out_tsof", out_tsof, m_q[0].sof);
      check("out_tlast", out_tlast, m_q[0].last);
    end
    check("in_tready", in_tready, exp_ready);
    check("frame_idx", frame_idx, m_idx);
    check("frame_pow", frame_pow, m_pow);
    check("missed_peaks", missed_peaks, m_missed);
    if (t_lastcap >= 0 && t_fall < 0 && busy === 1'b0) t_fall = cyc;
    rst_now   = reset | clear;
    g_in_beat = in_tvalid & exp_ready & !rst_now;
    out_xfer  = out_tready && m_q.size() != 0 && !rst_now;
    if (out_xfer) begin
      if (st_n == 0) st_first = out_tdata;
      st_lastd = out_tdata;
      st_n++;
      if (out_tsof === 1'b1) st_sof++;
      if (out_tlast === 1'b1) st_last++;
      void'(m_q.pop_front());
    end
    if (rst_now) model_reset();
    else         model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tvalid"}, out_tvalid, 1'b0);
    check({tag, "_tlast"}, out_tlast, 1'b0);
    check({tag, "_tsof"}, out_tsof, 1'b0);
    check({tag, "_tdata"}, out_tdata, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_tready"}, in_tready, 1'b1);
    check({tag, "_pow"}, frame_pow, '0);
    check({tag, "_idx"}, frame_idx, '0);
    check({tag, "_missed"}, missed_peaks, '0);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int s, since;
    bit f0, fa, fb, done;
    if (v.do_reset) begin
      reset = 1'b1; tick(); reset = 1'b0;
    end
    st_n = 0; st_sof = 0; st_last = 0; st_first = '0; st_lastd = '0;
    t_lastcap = -1; t_fall = -1;
    s = 0; since = 0; f0 = 0; fa = 0; fb = 0; done = 0;
    align_offset = CW'(v.align); nrx_after_peak = NW'(v.nrx);
    frame_len = CW'(v.flen); holdoff = CW'(v.hold);
    for (int c = 0; c < 1000 && !done; c++) begin
      in_tvalid = 1'b1;
      in_tdata  = 32'(s);
      peak_stb  = 1'b0;
      if (!f0 && s == v.peak_at) begin peak_stb = 1'b1; f0 = 1; end
      else if (f0 && !fa && s == v.xa) begin peak_stb = 1'b1; fa = 1; end
      else if (f0 && !fb && s == v.xb) begin peak_stb = 1'b1; fb = 1; end
      out_tready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      pow = PW'($urandom);
      if (v.abort > 0 && st_n == v.abort) begin
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_values($sformatf("v%0d_abort", vi));
        done = 1;
      end else begin
        tick();
        if (g_in_beat) s++;
        if (f0) since++;
        if (f0 && since >= 2 && !g_pre_busy && m_q.size() == 0) done = 1;
      end
    end
    peak_stb = 1'b0;
    check($sformatf("v%0d_finished", vi), done, 1'b1);
    check($sformatf("v%0d_beats", vi), st_n, v.e_n);
    check($sformatf("v%0d_first", vi), st_first, v.e_first);
    if (v.e_lastd >= 0) check($sformatf("v%0d_lastdata", vi), st_lastd, v.e_lastd);
    check($sformatf("v%0d_sof_cnt", vi), st_sof, v.e_sof);
    check($sformatf("v%0d_last_cnt", vi), st_last, v.e_last);
    check($sformatf("v%0d_missed", vi), missed_peaks, v.e_missed);
    check($sformatf("v%0d_idx", vi), frame_idx, v.e_idx);
    if (v.e_tail >= 0) check($sformatf("v%0d_busy_tail", vi), t_fall - t_lastcap, v.e_tail);
  endtask

  vec_t vt[9];

  initial begin
    checks = 0; failures = 0; cyc = 0;
    t_lastcap = -1; t_fall = -1; st_n = 0; st_sof = 0; st_last = 0;
    reset = 1'b1; clear = 1'b0; in_tvalid = 1'b0; in_tdata = '0; peak_stb = 1'b0;
    nrx_after_peak = '0; pow = '0; align_offset = '0; frame_len = '0; holdoff = '0;
    out_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;

    //         align nrx flen hold peak  xa  xb tog abort rst   n  first lastd sof last miss idx tail
    vt[0] = '{10,  4,   8,   0, 100, -1, -1, 0,  0,  1,    8, 107, 114, 1, 1, 0, 1, 2};
    vt[1] = '{10, 20,   4,   0,  50, -1, -1, 0,  0,  1,    4,  51,  54, 1, 1, 0, 1, 2};
    vt[2] = '{10,  4,  16,   0, 200, -1, -1, 1,  0,  1,   16, 207, 222, 1, 1, 0, 1, 2};
    vt[3] = '{ 3,  0,   0,   0, 300, -1, -1, 0,  0,  1,    1, 304, 304, 1, 1, 0, 1, 2};
    vt[4] = '{ 0,  0,   8,  32,  10, 14, 30, 0,  0,  1,    8,  11,  18, 1, 1, 2, 1, 33};
    vt[5] = '{10,  4,   8,   0, 100, -1, -1, 0,  3,  1,    3, 107,  -1, 1, 0, 0, 0, -1};
    vt[6] = '{10,  4,   8,   0, 100, -1, -1, 0,  0,  0,    8, 107, 114, 1, 1, 0, 1, 2};
    vt[7] = '{ 0,  0,   3,   5,  20, -1, -1, 0,  0,  1,    3,  21,  23, 1, 1, 0, 1, 6};
    vt[8] = '{ 5,  4,   2,   0,  30, -1, -1, 0,  0,  1,    2,  32,  33, 1, 1, 0, 1, 2};
    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Randomized traffic, backpressure, mid-frame control changes and soft clears.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      in_tvalid      = ($urandom % 4) != 0;
      in_tdata       = $urandom;
      peak_stb       = ($urandom % 20) == 0;
      out_tready     = ($urandom % 3) != 0;
      align_offset   = CW'($urandom % 12);
      nrx_after_peak = (($urandom % 8) == 0) ? NW'($urandom) : NW'($urandom % 14);
      frame_len      = CW'($urandom % 10);
      holdoff        = CW'($urandom % 6);
      pow            = PW'($urandom);
      clear          = ($urandom % 600) == 0;
      tick();
    end
    clear = 1'b0; peak_stb = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
